// File: rtl/jahangir_pkg.sv
// Shared definitions for the Jahangir MIPS32 pipeline registers.
package jahangir_pkg;

    // Bit positions in the pipeline-wide stall vector.
    localparam int unsigned STALL_PC  = 0;
    localparam int unsigned STALL_IF  = 1;
    localparam int unsigned STALL_ID  = 2;
    localparam int unsigned STALL_EX  = 3;
    localparam int unsigned STALL_MEM = 4;
    localparam int unsigned STALL_WB  = 5;

    // Default datapath widths.
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_DATA_W = 32;

    // Bubble contents: no destination, no data, no write.
    localparam logic [DEF_ADDR_W-1:0] NOP_ADDR = '0;
    localparam logic [DEF_DATA_W-1:0] NOP_DATA = '0;
    localparam logic                  NOP_WE   = 1'b0;

    // Per-edge behaviour of a pipeline register, highest priority first.
    typedef enum logic [1:0] {
        ModeFlush,
        ModeBubble,
        ModeHold,
        ModePass
    } pipe_mode_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with increment enable and asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: step by one unless already at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ex_mem.sv
// Execute -> memory pipeline register with stall/flush/bubble handling,
// a forwarding-valid flag and a saturating hold-cycle counter.
module ex_mem
    import jahangir_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  in_wr_address,
    input  logic [DATA_W-1:0]  in_wr_data,
    input  logic               in_wr_enable,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    output logic [ADDR_W-1:0]  out_wr_address,
    output logic [DATA_W-1:0]  out_wr_data,
    output logic               out_wr_enable,
    output logic               fwd_valid,
    output logic [CNT_W-1:0]   stall_cycles
);

    pipe_mode_e mode;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              we_q, we_d;
    logic              fwd_q, fwd_d;

    // Only the execute and memory stall bits matter here.
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_PC], stall[STALL_IF], stall[STALL_ID], stall[STALL_WB]};

    // Decode the per-edge mode; flush beats any stall combination.
    always_comb begin
        if (flush) begin
            mode = ModeFlush;
        end else if (stall[STALL_EX]) begin
            mode = stall[STALL_MEM] ? ModeHold : ModeBubble;
        end else begin
            mode = ModePass;
        end
    end

    // Next register contents for the selected mode.
    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        we_d   = we_q;
        fwd_d  = fwd_q;
        unique case (mode)
            ModeFlush, ModeBubble: begin
                addr_d = ADDR_W'(NOP_ADDR);
                data_d = DATA_W'(NOP_DATA);
                we_d   = NOP_WE;
                fwd_d  = 1'b0;
            end
            ModeHold: ;
            ModePass: begin
                addr_d = in_wr_address;
                data_d = in_wr_data;
                // A write to $0 is kept as-is; write-back discards it.
                we_d   = in_wr_enable;
                fwd_d  = in_wr_enable && (in_wr_address != '0);
            end
            default: ;
        endcase
    end

    // Pipeline register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            fwd_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
            we_q   <= we_d;
            fwd_q  <= fwd_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mode == ModeHold),
        .count (stall_cycles)
    );

    assign out_wr_address = addr_q;
    assign out_wr_data    = data_q;
    assign out_wr_enable  = we_q;
    assign fwd_valid      = fwd_q;

`ifndef SYNTHESIS
    // Memory stalled while execute runs would drop an instruction.
    a_stall_legal : assert property (@(posedge clk) disable iff (!rst_n)
        !(stall[STALL_MEM] && !stall[STALL_EX]))
        else $error("ex_mem: stall[4] set without stall[3]");
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed testbench for ex_mem with hand-computed expected values.
module tb_ex_mem;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned CNT_W   = 4;

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  in_wr_address;
    logic [DATA_W-1:0]  in_wr_data;
    logic               in_wr_enable;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [ADDR_W-1:0]  out_wr_address;
    logic [DATA_W-1:0]  out_wr_data;
    logic               out_wr_enable;
    logic               fwd_valid;
    logic [CNT_W-1:0]   stall_cycles;

    int unsigned n_tests;
    int unsigned n_fail;

    ex_mem #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .STALL_W (STALL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_wr_address  (in_wr_address),
        .in_wr_data     (in_wr_data),
        .in_wr_enable   (in_wr_enable),
        .stall          (stall),
        .flush          (flush),
        .out_wr_address (out_wr_address),
        .out_wr_data    (out_wr_data),
        .out_wr_enable  (out_wr_enable),
        .fwd_valid      (fwd_valid),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                         input logic we);
        in_wr_address = a;
        in_wr_data    = d;
        in_wr_enable  = we;
    endtask

    task automatic check_out(input string tag, input logic [ADDR_W-1:0] a,
                             input logic [DATA_W-1:0] d, input logic we, input logic fv,
                             input logic [CNT_W-1:0] cnt);
        check({tag, ".addr"}, 64'(out_wr_address), 64'(a));
        check({tag, ".data"}, 64'(out_wr_data), 64'(d));
        check({tag, ".we"}, 64'(out_wr_enable), 64'(we));
        check({tag, ".fwd"}, 64'(fwd_valid), 64'(fv));
        check({tag, ".cnt"}, 64'(stall_cycles), 64'(cnt));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        stall   = '0;
        flush   = 1'b0;
        drive(5'd0, 32'h0, 1'b0);

        #2;
        check_out("reset", 5'd0, 32'h0, 1'b0, 1'b0, 4'd0);
        #10 rst_n = 1'b1;

        // Load an entry, hold it one cycle, then reset between edges.
        drive(5'd5, 32'hDEAD_BEEF, 1'b1);
        step();
        check_out("pre_rst", 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b1, 4'd0);
        stall = 6'b011111;
        step();
        check("pre_rst.cnt_hold", 64'(stall_cycles), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        check_out("async_rst", 5'd0, 32'h0, 1'b0, 1'b0, 4'd0);
        stall = '0;
        #2 rst_n = 1'b1;

        // PASS
        drive(5'd3, 32'h0000_F0F0, 1'b1);
        step();
        check_out("pass", 5'd3, 32'h0000_F0F0, 1'b1, 1'b1, 4'd0);

        // Write enable low on a real register: not forwardable.
        drive(5'd12, 32'h0BAD_CAFE, 1'b0);
        step();
        check_out("pass_we0", 5'd12, 32'h0BAD_CAFE, 1'b0, 1'b0, 4'd0);

        // HOLD for 4 cycles with changing inputs.
        drive(5'd7, 32'h1234_5678, 1'b1);
        step();
        stall = 6'b011111;
        for (int i = 0; i < 4; i++) begin
            drive(5'(i + 20), 32'hFFFF_0000 + 32'(i), i[0]);
            step();
        end
        check_out("hold", 5'd7, 32'h1234_5678, 1'b1, 1'b1, 4'd4);

        // BUBBLE then resume.
        stall = 6'b001111;
        drive(5'd11, 32'h7777_7777, 1'b1);
        step();
        check_out("bubble", 5'd0, 32'h0, 1'b0, 1'b0, 4'd4);
        stall = '0;
        drive(5'd9, 32'hA5A5_A5A5, 1'b1);
        step();
        check_out("resume", 5'd9, 32'hA5A5_A5A5, 1'b1, 1'b1, 4'd4);

        // Flush beats a full hold and leaves the counter alone.
        stall = 6'b011111;
        flush = 1'b1;
        drive(5'd14, 32'h1111_2222, 1'b1);
        step();
        check_out("flush", 5'd0, 32'h0, 1'b0, 1'b0, 4'd4);
        flush = 1'b0;

        // Saturation: 4 + 20 holds clamps at 15.
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat.cnt", 64'(stall_cycles), 64'd15);

        // $0 write keeps its enable but is not forwardable.
        stall = '0;
        drive(5'd0, 32'h0000_0055, 1'b1);
        step();
        check_out("zero_reg", 5'd0, 32'h0000_0055, 1'b1, 1'b0, 4'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
